// File: rtl/rr_logb_unpacker_if.sv
// Beat bus for rr_logb_unpacker: the input beat handshake plus the per-channel
// replay push outputs and their almost-full backpressure.
interface rr_logb_unpacker_if #(
    parameter int NUM_CH     = 3,
    parameter int DATA_WIDTH = 64
);
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_WIDTH-1:0]        in_data;
    logic [NUM_CH-1:0]            out_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] out_data;
    logic [NUM_CH-1:0]            out_almful;

    modport master (
        output in_valid, in_data, out_almful,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_almful,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/rr_logb_unpacker.sv
// Replay-side log stream decoder: a header beat (logb mask, loge mask) is
// followed by one payload beat per set logb bit, routed in ascending channel
// order to one-cycle push strobes. Counts completed records.
// Optional macro RR_UNPACK_CHECK_EN: flags malformed headers on hdr_err
// (sticky) and discards headers with nonzero reserved bits.
module rr_logb_unpacker #(
    parameter int NUM_CH     = 3,
    parameter int DATA_WIDTH = 64,
    parameter int LOGE_CNT   = 5
) (
    input  logic                clk,
    input  logic                rstn,
    rr_logb_unpacker_if.slave   bus,
    output logic                rec_valid,
    output logic [LOGE_CNT-1:0] rec_loge,
    output logic [31:0]         rec_cnt,
    output logic                hdr_err
);

    typedef enum logic {HDR, PAYLOAD} state_e;

    state_e                       state_q, state_d;
    logic [NUM_CH-1:0]            pend_q, pend_d;
    logic [LOGE_CNT-1:0]          loge_q, loge_d;
    logic                         first_q, first_d;
    logic [NUM_CH-1:0]            out_valid_q, out_valid_d;
    logic [NUM_CH*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                         rec_valid_q, rec_valid_d;
    logic [LOGE_CNT-1:0]          rec_loge_q, rec_loge_d;
    logic [31:0]                  rec_cnt_q, rec_cnt_d;
    logic                         hdr_err_q, hdr_err_d;

    logic                         accept;
    logic                         routed;
    logic [NUM_CH-1:0]            hdr_logb;
    logic [LOGE_CNT-1:0]          hdr_loge;
    logic                         hdr_take;

    // Payload state has guaranteed FIFO headroom, so only headers wait on almful.
    assign bus.in_ready = rstn && ((state_q == PAYLOAD) || !(|bus.out_almful));
    assign accept       = bus.in_valid && bus.in_ready;
    assign hdr_logb     = bus.in_data[NUM_CH-1:0];
    assign hdr_loge     = bus.in_data[NUM_CH +: LOGE_CNT];

`ifdef RR_UNPACK_CHECK_EN
    logic hdr_rsvd_nz;
    assign hdr_rsvd_nz = |(bus.in_data >> (NUM_CH + LOGE_CNT));
    assign hdr_take    = (|hdr_logb) && !hdr_rsvd_nz;
`else
    assign hdr_take    = |hdr_logb;
`endif

    // Header decode, lowest-pending-channel routing and record bookkeeping.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        loge_d      = loge_q;
        first_d     = first_q;
        out_valid_d = '0;
        out_data_d  = out_data_q;
        rec_valid_d = 1'b0;
        rec_loge_d  = rec_loge_q;
        rec_cnt_d   = rec_cnt_q;
        hdr_err_d   = hdr_err_q;
        routed      = 1'b0;

        if (accept) begin
            if (state_q == HDR) begin
`ifdef RR_UNPACK_CHECK_EN
                if (hdr_rsvd_nz || (!(|hdr_logb) && (|hdr_loge))) begin
                    hdr_err_d = 1'b1;
                end
`endif
                if (hdr_take) begin
                    pend_d  = hdr_logb;
                    loge_d  = hdr_loge;
                    first_d = 1'b1;
                    state_d = PAYLOAD;
                end
            end else begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (pend_q[i] && !routed) begin
                        routed                             = 1'b1;
                        pend_d[i]                          = 1'b0;
                        out_valid_d[i]                     = 1'b1;
                        out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
                    end
                end
                if (first_q) begin
                    rec_valid_d = 1'b1;
                    rec_loge_d  = loge_q;
                    first_d     = 1'b0;
                end
                if (pend_d == '0) begin
                    rec_cnt_d = rec_cnt_q + 32'd1;
                    state_d   = HDR;
                end
            end
        end
    end

    // State and output registers; reset drops any partial record.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= HDR;
            pend_q      <= '0;
            loge_q      <= '0;
            first_q     <= 1'b0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            rec_valid_q <= 1'b0;
            rec_loge_q  <= '0;
            rec_cnt_q   <= '0;
            hdr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            loge_q      <= loge_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rec_valid_q <= rec_valid_d;
            rec_loge_q  <= rec_loge_d;
            rec_cnt_q   <= rec_cnt_d;
            hdr_err_q   <= hdr_err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign rec_valid     = rec_valid_q;
    assign rec_loge      = rec_loge_q;
    assign rec_cnt       = rec_cnt_q;
`ifdef RR_UNPACK_CHECK_EN
    assign hdr_err       = hdr_err_q;
`else
    assign hdr_err       = 1'b0;
`endif

endmodule

// File: tb/tb_rr_logb_unpacker.sv
// Directed bench for rr_logb_unpacker with a queue-based record model that is
// compared against the DUT every cycle, plus literal spot checks.
module tb_rr_logb_unpacker;

    localparam int NCH = 3;
    localparam int DW  = 64;
    localparam int LC  = 5;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    logic          rec_valid;
    logic [LC-1:0] rec_loge;
    logic [31:0]   rec_cnt;
    logic          hdr_err;

    rr_logb_unpacker_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus ();

    rr_logb_unpacker #(.NUM_CH(NCH), .DATA_WIDTH(DW), .LOGE_CNT(LC)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .rec_valid (rec_valid),
        .rec_loge  (rec_loge),
        .rec_cnt   (rec_cnt),
        .hdr_err   (hdr_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_pend[$];
    logic            m_first = 1'b0;
    logic [LC-1:0]   m_loge  = '0;
    logic [NCH-1:0]  e_valid = '0;
    logic [NCH*DW-1:0] e_data = '0;
    logic            e_rv    = 1'b0;
    logic [LC-1:0]   e_loge  = '0;
    logic [31:0]     m_cnt   = '0;
    logic            e_err   = 1'b0;

    function automatic logic m_ready();
        return rstn && ((m_pend.size() != 0) || !(|bus.out_almful));
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pend.delete();
            m_first = 1'b0;
            e_valid = '0;
            e_data  = '0;
            e_rv    = 1'b0;
            e_loge  = '0;
            m_cnt   = '0;
            e_err   = 1'b0;
        end else begin
            logic ok;
            logic [2:0]  lb;
            logic [4:0]  le;
            logic [55:0] rs;
            ok      = m_ready();
            e_valid = '0;
            e_rv    = 1'b0;
            if (bus.in_valid && ok) begin
                if (m_pend.size() == 0) begin
                    lb = bus.in_data[2:0];
                    le = bus.in_data[7:3];
                    rs = bus.in_data[63:8];
`ifdef RR_UNPACK_CHECK_EN
                    if (rs != 0 || (lb == 0 && le != 0)) e_err = 1'b1;
                    if (rs != 0) lb = '0;
`endif
                    if (lb != 0) begin
                        for (int c = 0; c < NCH; c++) if (lb[c]) m_pend.push_back(c);
                        m_first = 1'b1;
                        m_loge  = le;
                    end
                end else begin
                    int c;
                    c = m_pend.pop_front();
                    e_valid[c] = 1'b1;
                    e_data[c*DW +: DW] = bus.in_data;
                    if (m_first) begin
                        e_rv    = 1'b1;
                        e_loge  = m_loge;
                        m_first = 1'b0;
                    end
                    if (m_pend.size() == 0) m_cnt = m_cnt + 32'd1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, m_ready()});
        chk("out_valid", {61'd0, bus.out_valid}, {61'd0, e_valid});
        for (int c = 0; c < NCH; c++)
            chk($sformatf("out_data[%0d]", c), bus.out_data[c*DW +: DW], e_data[c*DW +: DW]);
        chk("rec_valid", {63'd0, rec_valid}, {63'd0, e_rv});
        if (e_rv) chk("rec_loge", {59'd0, rec_loge}, {59'd0, e_loge});
        chk("rec_cnt", {32'd0, rec_cnt}, {32'd0, m_cnt});
        chk("hdr_err", {63'd0, hdr_err}, {63'd0, e_err});
    end

    // ---------------- stimulus ----------------
    function automatic logic [63:0] hdr(input logic [2:0] lb, input logic [4:0] le);
        return {56'd0, le, lb};
    endfunction

    // Present one beat until accepted; returns cycles spent waiting.
    task automatic send(input logic [63:0] d, output int waited);
        logic rdy;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 40) begin
                chk("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int w;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_almful = '0;
        rstn           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_rec_cnt", {32'd0, rec_cnt}, 64'd0);
        chk("rst_out_valid", {61'd0, bus.out_valid}, 64'd0);
        rstn = 1'b1;
        idle(1);

        // Record logb=101 loge=00011, payloads 0xA then 0xB.
        send(hdr(3'b101, 5'b00011), w);
        send(64'hA, w);
        chk("t1_ov0", {61'd0, bus.out_valid}, 64'b001);
        chk("t1_d0", bus.out_data[63:0], 64'hA);
        chk("t1_rv", {63'd0, rec_valid}, 64'd1);
        chk("t1_loge", {59'd0, rec_loge}, 64'b00011);
        send(64'hB, w);
        chk("t1_ov2", {61'd0, bus.out_valid}, 64'b100);
        chk("t1_d2", bus.out_data[191:128], 64'hB);
        chk("t1_rv_once", {63'd0, rec_valid}, 64'd0);
        chk("t1_cnt", {32'd0, rec_cnt}, 64'd1);
        chk("t1_model_cnt", {32'd0, m_cnt}, 64'd1);
        idle(2);

        // Padding between two single-channel records.
        send(hdr(3'b010, 5'b0), w);
        send(64'h11, w);
        chk("t2_ov1a", {61'd0, bus.out_valid}, 64'b010);
        send(64'h0, w);
        chk("t2_pad_nopush", {61'd0, bus.out_valid}, 64'd0);
        send(hdr(3'b010, 5'b0), w);
        send(64'h22, w);
        chk("t2_ov1b", {61'd0, bus.out_valid}, 64'b010);
        chk("t2_d1", bus.out_data[127:64], 64'h22);
        chk("t2_cnt", {32'd0, rec_cnt}, 64'd3);
        idle(2);

        // Almost-full stalls the header but not the payloads.
        bus.out_almful = 3'b010;
        bus.in_valid   = 1'b1;
        bus.in_data    = hdr(3'b111, 5'b10000);
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall", {63'd0, bus.in_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        bus.out_almful = '0;
        send(hdr(3'b111, 5'b10000), w);
        chk("t3_hdr_wait", w, 0);
        bus.out_almful = '1;
        send(64'h100, w);
        chk("t3_p0_wait", w, 0);
        send(64'h101, w);
        chk("t3_p1_wait", w, 0);
        send(64'h102, w);
        chk("t3_p2_wait", w, 0);
        chk("t3_ov2", {61'd0, bus.out_valid}, 64'b100);
        chk("t3_cnt", {32'd0, rec_cnt}, 64'd4);
        idle(1);
        chk("t3_hdr_blocked", {63'd0, bus.in_ready}, 64'd0);
        bus.out_almful = '0;
        idle(1);

        // Malformed header: logb zero, loge nonzero.
        send(hdr(3'b000, 5'b00001), w);
        idle(2);
        chk("t4_nopush", {61'd0, bus.out_valid}, 64'd0);
`ifdef RR_UNPACK_CHECK_EN
        chk("t4_err", {63'd0, hdr_err}, 64'd1);
        send(64'h101, w);
        idle(2);
        chk("t4_rsvd_nopush", {61'd0, bus.out_valid}, 64'd0);
`else
        chk("t4_err", {63'd0, hdr_err}, 64'd0);
`endif
        send(hdr(3'b001, 5'b0), w);
        send(64'h5, w);
        chk("t4_ov0", {61'd0, bus.out_valid}, 64'b001);
        chk("t4_cnt", {32'd0, rec_cnt}, 64'd5);
`ifdef RR_UNPACK_CHECK_EN
        chk("t4_err_sticky", {63'd0, hdr_err}, 64'd1);
`else
        chk("t4_err_sticky", {63'd0, hdr_err}, 64'd0);
`endif
        idle(2);

        // Reset mid-record, then a channel-2 record.
        send(hdr(3'b011, 5'b0), w);
        send(64'h33, w);
        rstn = 1'b0;
        idle(2);
        chk("t5_rst_cnt", {32'd0, rec_cnt}, 64'd0);
        chk("t5_rst_rdy", {63'd0, bus.in_ready}, 64'd0);
        rstn = 1'b1;
        idle(1);
        send(hdr(3'b100, 5'b0), w);
        send(64'h44, w);
        chk("t5_ov2", {61'd0, bus.out_valid}, 64'b100);
        chk("t5_d2", bus.out_data[191:128], 64'h44);
        chk("t5_d0_cleared", bus.out_data[63:0], 64'h0);
        chk("t5_cnt", {32'd0, rec_cnt}, 64'd1);
        idle(2);

        // Counter wrap.
        force dut.rec_cnt_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        idle(1);
        release dut.rec_cnt_q;
        idle(1);
        chk("t6_preload", {32'd0, rec_cnt}, 64'hFFFF_FFFF);
        send(hdr(3'b001, 5'b0), w);
        send(64'h55, w);
        chk("t6_wrap", {32'd0, rec_cnt}, 64'd0);
        chk("t6_model_wrap", {32'd0, m_cnt}, 64'd0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
